// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg
// Shared definitions for the universal shift register:
//   - MODE_* : 3-bit operation codes driven on univ_shift_reg.mode
//   - cnt_width(width) : width of the shift counter able to hold 0..width-1
package univ_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_SET  = 3'b111;

    // One spare bit over $clog2 keeps power-of-two widths representable.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/word_cnt.sv
// word_cnt
// Modulo-WIDTH shift counter with a registered wrap pulse.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   inc    : count one shift this edge
//   clr    : restart the word (wins over inc)
//   cnt    : shifts counted in the current word, 0..WIDTH-1
//   wrap   : high for one cycle after the edge that completes a word
module word_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;   // wrap is a pulse: any edge not finishing a word clears it
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// WIDTH-bit universal register: hold, shift/rotate left/right, load, clear,
// set, all gated by en. A word counter pulses word_done after every WIDTH
// counted shifts/rotates so the block can act as a SERDES.
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset (beats en/mode)
//   en, mode        : operation enable and select (univ_reg_pkg::MODE_*)
//   d               : parallel load data
//   sin_r, sin_l    : serial inputs entering MSB (SHR) / LSB (SHL)
//   q, qn           : register contents and its complement
//   sout_r, sout_l  : q[0] and q[WIDTH-1]
//   shift_cnt       : counted operations in the current word
//   word_done       : one-cycle pulse after the WIDTH-th counted operation
module univ_shift_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             cnt_inc;
    logic             cnt_clr;

    always_comb begin
        q_d     = q_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR: begin
                    q_d     = {sin_r, q_q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], sin_l};
                    cnt_inc = 1'b1;
                end
                MODE_LOAD: begin
                    q_d     = d;
                    cnt_clr = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cnt_inc = 1'b1;
                end
                MODE_CLR: begin
                    q_d     = '0;
                    cnt_clr = 1'b1;
                end
                MODE_SET: begin
                    q_d     = '1;
                    cnt_clr = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    word_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (shift_cnt),
        .wrap  (word_done)
    );

    assign q      = q_q;
    assign qn     = ~q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg
// Directed scenarios plus a randomized run for univ_shift_reg (WIDTH=8),
// checked against a word-level reference model held in the bench.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  q;
    logic [W-1:0]  qn;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    int total = 0;
    int bad   = 0;

    // reference model state (post-edge view)
    logic [W-1:0] m_q    = '0;
    int           m_cnt  = 0;
    logic         m_done = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .qn        (qn),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic rn, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dd, input logic sr, input logic sl);
        logic [W-1:0] nq;
        int           ncnt;
        logic         ndone;
        logic [W-1:0] msb_r;
        rst_n = rn; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        nq    = m_q;
        ncnt  = m_cnt;
        ndone = 1'b0;
        msb_r = {sr, {(W-1){1'b0}}};
        if (!rn) begin
            nq = '0; ncnt = 0;
        end else if (e) begin
            case (m)
                3'd1: nq = (m_q >> 1) | msb_r;
                3'd2: nq = (m_q << 1) | W'(sl);
                3'd3: nq = dd;
                3'd4: nq = (m_q >> 1) | (m_q << (W - 1));
                3'd5: nq = (m_q << 1) | (m_q >> (W - 1));
                3'd6: nq = '0;
                3'd7: nq = '1;
                default: nq = m_q;
            endcase
            if (m inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
                ncnt = m_cnt + 1;
                if (ncnt == W) begin
                    ncnt  = 0;
                    ndone = 1'b1;
                end
            end else if (m inside {3'd3, 3'd6, 3'd7}) begin
                ncnt = 0;
            end
        end
        @(posedge clk);
        #1;
        m_q = nq; m_cnt = ncnt; m_done = ndone;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++; if (qn !== 8'hFF) begin bad++; $display("FAIL reset_qn got=%h exp=ff", qn); end
        total++; if (shift_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
        total++; if (word_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", word_done); end
    endtask

    task automatic test_shifts();
        step(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        total++; if (q !== 8'hD2) begin bad++; $display("FAIL shr_q got=%h exp=d2", q); end
        total++; if (shift_cnt !== 4'd1) begin bad++; $display("FAIL shr_cnt got=%0d exp=1", shift_cnt); end
        step(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL load_cnt got=%0d exp=0", shift_cnt); end
        step(1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        total++; if (q !== 8'h4A) begin bad++; $display("FAIL shl_q got=%h exp=4a", q); end
        total++; if (shift_cnt !== 4'd1) begin bad++; $display("FAIL shl_cnt got=%0d exp=1", shift_cnt); end
        total++; if (sout_l !== 1'b0 || sout_r !== 1'b0) begin bad++; $display("FAIL shl_sout got=%b%b exp=00", sout_l, sout_r); end
    endtask

    task automatic test_rotates();
        step(1'b1, 1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        total++; if (q !== 8'hC0) begin bad++; $display("FAIL ror_q got=%h exp=c0", q); end
        step(1'b1, 1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        total++; if (q !== 8'h03) begin bad++; $display("FAIL rol_q got=%h exp=03", q); end
        step(1'b1, 1'b1, 3'd6, 8'h5A, 1'b1, 1'b1);
        total++; if (q !== 8'h00 || shift_cnt !== 4'd0) begin bad++; $display("FAIL clr got=%h/%0d exp=00/0", q, shift_cnt); end
        step(1'b1, 1'b1, 3'd7, 8'h5A, 1'b0, 1'b0);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL set_q got=%h exp=ff", q); end
        step(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL hold_q got=%h exp=ff", q); end
    endtask

    task automatic test_serialiser();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0100;  // LSB first: 0,0,1,0,1,1,0,1
        step(1'b1, 1'b1, 3'd3, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sout_r !== exp_bits[i]) begin bad++; $display("FAIL ser_bit%0d got=%b exp=%b", i, sout_r, exp_bits[i]); end
            step(1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
            total++;
            if (word_done !== (i == 7)) begin bad++; $display("FAIL ser_done%0d got=%b exp=%b", i, word_done, (i == 7)); end
        end
        total++; if (q !== 8'h00 || shift_cnt !== 4'd0) begin bad++; $display("FAIL ser_end got=%h/%0d exp=00/0", q, shift_cnt); end
        step(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (word_done !== 1'b0) begin bad++; $display("FAIL ser_pulse_len got=%b exp=0", word_done); end
    endtask

    task automatic test_enable_freeze();
        step(1'b1, 1'b1, 3'd3, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b1);
            total++;
            if (q !== 8'h16 || shift_cnt !== 4'd3 || word_done !== 1'b0) begin
                bad++; $display("FAIL freeze%0d got=%h/%0d/%b exp=16/3/0", i, q, shift_cnt, word_done);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
            total++;
            if (word_done !== (i == 4)) begin bad++; $display("FAIL freeze_done%0d got=%b exp=%b", i, word_done, (i == 4)); end
        end
    endtask

    task automatic test_restart();
        step(1'b1, 1'b1, 3'd3, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        total++; if (q !== 8'h00 || shift_cnt !== 4'd0) begin bad++; $display("FAIL rst_mid got=%h/%0d exp=00/0", q, shift_cnt); end
        step(1'b1, 1'b1, 3'd3, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b1, 3'd3, 8'h3C, 1'b0, 1'b0);
        total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL load_mid got=%0d exp=0", shift_cnt); end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
            total++;
            if (word_done !== (i == 7)) begin bad++; $display("FAIL load_done%0d got=%b exp=%b", i, word_done, (i == 7)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            total++;
            if (sout_r !== m_q[0] || sout_l !== m_q[W-1]) begin
                bad++; $display("FAIL rnd_sout%0d got=%b%b exp=%b%b", i, sout_l, sout_r, m_q[W-1], m_q[0]);
            end
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom));
            total++;
            if (q !== m_q || qn !== ~m_q || shift_cnt !== CW'(m_cnt) || word_done !== m_done) begin
                bad++;
                $display("FAIL rnd%0d got q=%h qn=%h cnt=%0d done=%b exp q=%h qn=%h cnt=%0d done=%b",
                         i, q, qn, shift_cnt, word_done, m_q, ~m_q, m_cnt, m_done);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_shifts();
        test_rotates();
        test_serialiser();
        test_enable_freeze();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register with synchronous active-low reset: parallel load, shift left/right, rotate left/right, clear, set and hold, all under a single enable. It generalises the single-bit enabled D flip-flop to a WIDTH-bit word. It adds a shift counter that pulses `word_done` after every WIDTH shifts, so the block doubles as a serialiser/deserialiser in the lab designs.

## Interface
- `WIDTH`, default 8: register width in bits; legal range 2..64.
- `RESET_VAL`, default 0: value loaded into `q` on reset, WIDTH bits.
- `CNT_W`, default $clog2(WIDTH)+1: width of `shift_cnt`; derived, not to be overridden.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, synchronous and active-low; has priority over `en` and `mode`.
- `en`  input  1: operation enable; when 0 all state holds.
- `mode`  input  3: operation select (encoding under Operation).
- `d`  input  WIDTH: parallel load data.
- `sin_r`  input  1: serial input for shift right; enters the MSB.
- `sin_l`  input  1: serial input for shift left; enters the LSB.
- `q`  output  WIDTH: register contents.
- `qn`  output  WIDTH: bitwise complement of `q`; combinational.
- `sout_r`  output  1: `q[0]`; combinational.
- `sout_l`  output  1: `q[WIDTH-1]`; combinational.
- `shift_cnt`  output  CNT_W: shifts and rotates since the last LOAD, CLR, SET or reset.
- `word_done`  output  1: registered one-cycle pulse after the WIDTH-th counted shift.

## Operation
- Mode encoding, applied only when `en`=1 and `rst_n`=1:
  - 000 HOLD: `q` unchanged.
  - 001 SHR: `q <= {sin_r, q[WIDTH-1:1]}`.
  - 010 SHL: `q <= {q[WIDTH-2:0], sin_l}`.
  - 011 LOAD: `q <= d`.
  - 100 ROR: `q <= {q[0], q[WIDTH-1:1]}`.
  - 101 ROL: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
  - 110 CLR: `q <= 0`.
  - 111 SET: `q <= all ones`.
- Shift counter:
  - SHR, SHL, ROR and ROL are counted operations.
  - A counted operation with `shift_cnt` < WIDTH-1 increments `shift_cnt`.
  - A counted operation with `shift_cnt` = WIDTH-1 sets `shift_cnt <= 0` and `word_done <= 1`.
- LOAD, CLR and SET set `shift_cnt <= 0`. These are the only ways to restart a word other than reset.
- HOLD leaves `shift_cnt` unchanged.
- `word_done` is 0 after any edge that does not complete a word. This includes edges with `en`=0.
- `en`=0 freezes `q` and `shift_cnt`; `word_done` returns to 0.
- Reset (`rst_n`=0 at an edge) sets `q <= RESET_VAL`, `shift_cnt <= 0` and `word_done <= 0`. This applies regardless of `en`, `mode` or an in-progress word; the partially shifted word is discarded.
- Modes are mutually exclusive by encoding, so operations never occur simultaneously.

## Timing
- All register updates have 1-cycle latency: inputs are sampled at edge k and `q` is valid after edge k.
- `qn`, `sout_r` and `sout_l` follow `q` combinationally, with no extra latency.
- Serialiser timing: `sout_r` before edge k is the bit shifted out at edge k.
- `word_done` is high for exactly one cycle, the cycle following the edge that performs the WIDTH-th counted operation. A back-to-back next word can pulse again WIDTH cycles later.
- No combinational path exists from any input to `word_done` or `shift_cnt`.

## Structure
- Package `univ_reg_pkg` holds:
  - The mode localparams MODE_HOLD … MODE_SET, 3-bit.
  - The function `cnt_width(WIDTH)`.
- Sub-module `word_cnt`:
  - Contents: CNT_W-bit modulo-WIDTH counter with synchronous active-low reset.
  - Inputs: `inc` and `clr`.
  - Output: registered `wrap` pulse.
  - The top level instantiates one `word_cnt` and implements the mode mux inline.

## Test plan
- Reset priority: `rst_n`=0, `en`=1, LOAD, `d`=8'hA5 -> after the edge, `q`=8'h00, `qn`=8'hFF, `shift_cnt`=0, `word_done`=0.
- Shifts: LOAD 8'hA5.
  - Then SHR with `sin_r`=1 -> `q`=8'hD2.
  - Then reload 8'hA5 and SHL with `sin_l`=0 -> `q`=8'h4A.
  - `shift_cnt`=1 after each shift.
- Rotates: LOAD 8'h81.
  - Then ROR -> 8'hC0.
  - Reload 8'h81, then ROL -> 8'h03.
  - CLR -> 8'h00; SET -> 8'hFF; HOLD keeps 8'hFF.
- Serialiser: LOAD 8'hB4, then 8 consecutive SHR with `sin_r`=0.
  - `sout_r` sampled before each edge reads 0,0,1,0,1,1,0,1.
  - `word_done`=1 only in the cycle after the 8th shift.
  - After that edge, `q`=8'h00 and `shift_cnt`=0.
- Enable freeze: after 3 SHRs on 8'hB4, hold `en`=0 for 3 cycles with mode=SHR.
  - `q`=8'h16 and `shift_cnt`=3 stay frozen.
  - `word_done` pulses only after 5 further enabled shifts.
- Restart and abort:
  - Reset mid-word: 5 SHRs, then `rst_n`=0 -> `q`=RESET_VAL and `shift_cnt`=0.
  - LOAD mid-word: 3 shifts, then LOAD -> `shift_cnt`=0, and `word_done` fires only 8 shifts after the LOAD.
